// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel source and its helpers: visible-area
// geometry, the 12-bit {B,G,R} colour type and the frame state encoding.
package vga_pkg;

    localparam int H_VIS  = 640;
    localparam int V_VIS  = 480;
    localparam int H_LAST = H_VIS - 1;
    localparam int V_LAST = V_VIS - 1;

    // Pixel colour, {B[11:8], G[7:4], R[3:0]}.
    typedef logic [11:0] color_t;

    localparam color_t COLOR_OFF        = 12'h000;
    localparam color_t COLOR_DEF_BG     = 12'h0C4;
    localparam color_t COLOR_DEF_SPRITE = 12'h0FF;
    localparam color_t COLOR_DEF_BORDER = 12'hFFF;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        VBLANK   = 2'd2
    } state_t;

endpackage

// File: rtl/vga_pixel_source_if.sv
// Read bus from the VGA driver plus the sprite-position update handshake from
// game logic. The master side is whoever drives requests and updates; the
// pixel source is the slave.
interface vga_pixel_source_if;
    import vga_pkg::*;

    logic [8:0] row;
    logic [9:0] col;
    logic       rdn;
    color_t     Din;
    logic       upd_valid;
    logic [9:0] upd_x;
    logic [8:0] upd_y;
    logic       upd_ready;

    modport master (
        output row, col, rdn, upd_valid, upd_x, upd_y,
        input  Din, upd_ready
    );

    modport slave (
        input  row, col, rdn, upd_valid, upd_x, upd_y,
        output Din, upd_ready
    );

endinterface

// File: rtl/vga_rect_hit.sv
// Combinational rectangle membership test. The right/bottom bounds are formed
// 11 bits wide so a rectangle hanging past the screen edge is clipped rather
// than wrapping back to column/row 0.
module vga_rect_hit (
    input  logic [8:0] row,
    input  logic [9:0] col,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic [9:0] w,
    input  logic [8:0] h,
    output logic       hit
);

    logic [10:0] x_end;
    logic [10:0] y_end;

    // Exclusive right/bottom bounds, then the four-sided compare.
    always_comb begin
        x_end = {1'b0, x} + {1'b0, w};
        y_end = {2'b0, y} + {2'b0, h};
        hit   = (col >= x) && ({1'b0, col} < x_end) &&
                (row >= y) && ({2'b0, row} < y_end);
    end

endmodule

// File: rtl/vga_pixel_source.sv
// Pixel responder for the VGA driver: background plus one rectangular sprite.
// Din is purely combinational from the request and the sprite registers.
// Sprite position updates are only accepted outside the visible area so no
// frame ever shows a half-moved sprite.
// Optional build macro VGA_PIXEL_BORDER_EN draws a one-pixel screen border
// in BORDER_COLOR on top of everything else.
module vga_pixel_source
    import vga_pkg::*;
#(
    parameter int     SPR_W     = 32,
    parameter int     SPR_H     = 24,
    parameter color_t BG_COLOR  = COLOR_DEF_BG,
    parameter color_t SPR_COLOR = COLOR_DEF_SPRITE
`ifdef VGA_PIXEL_BORDER_EN
    ,
    parameter color_t BORDER_COLOR = COLOR_DEF_BORDER
`endif
) (
    input  logic                clk_25MHz,
    input  logic                rst,
    vga_pixel_source_if.slave   bus,
    output logic                frame_start,
    output logic [15:0]         frame_cnt
);

    localparam logic [9:0] SPR_W_V = 10'(SPR_W);
    localparam logic [8:0] SPR_H_V = 9'(SPR_H);

    state_t     state_q;
    state_t     state_d;
    logic [9:0] spr_x;
    logic [8:0] spr_y;
    logic       spr_hit;
    logic       req_sof;
    logic       req_last;
    logic       enter_active;

    vga_rect_hit u_bird_hit (
        .row (bus.row),
        .col (bus.col),
        .x   (spr_x),
        .y   (spr_y),
        .w   (SPR_W_V),
        .h   (SPR_H_V),
        .hit (spr_hit)
    );

    // Decode the first and last visible pixel of a frame from the request.
    always_comb begin
        req_sof  = !bus.rdn && (bus.row == 9'd0) && (bus.col == 10'd0);
        req_last = !bus.rdn && (bus.row == 9'(V_LAST)) && (bus.col == 10'(H_LAST));
    end

    // Frame state register; reset always lands in WAIT_SOF so a partial
    // frame after reset is ignored.
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_SOF;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values,
            // regardless of the order the always blocks are evaluated in.
            state_q <= state_d;
        end
    end

    // Next-state logic: frames open on (0,0) and close after (479,639).
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d
        // unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            WAIT_SOF: if (req_sof)  state_d = ACTIVE;
            ACTIVE:   if (req_last) state_d = VBLANK;
            VBLANK:   if (req_sof)  state_d = ACTIVE;
            default:  state_d = WAIT_SOF;
        endcase
    end

    // State decodes: updates are welcome whenever no frame is being drawn,
    // including the SOF cycle itself.
    always_comb begin
        bus.upd_ready = (state_q != ACTIVE);
        enter_active  = (state_q != ACTIVE) && (state_d == ACTIVE);
    end

    // Frame-start pulse and frame counter, both registered off the SOF
    // transition; the counter wraps naturally at 16 bits.
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            frame_start <= enter_active;
            if (enter_active) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Sprite position capture; the last accepted update before SOF wins.
    // Out-of-range positions are stored as-is and simply never hit.
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            spr_x <= 10'd0;
            spr_y <= 9'd0;
        end else if (bus.upd_valid && bus.upd_ready) begin
            spr_x <= bus.upd_x;
            spr_y <= bus.upd_y;
        end
    end

    // Pixel colour: blank when not reading, then border, sprite, background.
    always_comb begin
        if (bus.rdn) begin
            bus.Din = COLOR_OFF;
`ifdef VGA_PIXEL_BORDER_EN
        end else if ((bus.row == 9'd0) || (bus.row == 9'(V_LAST)) ||
                     (bus.col == 10'd0) || (bus.col == 10'(H_LAST))) begin
            bus.Din = BORDER_COLOR;
`endif
        end else if (spr_hit) begin
            bus.Din = SPR_COLOR;
        end else begin
            bus.Din = BG_COLOR;
        end
    end

endmodule

// File: tb/tb_vga_pixel_source.sv
// Self-checking bench for vga_pixel_source. A frame-level reference model
// (in-frame flag, frame count, sprite position) predicts every output, and
// pixel colours come straight from the rectangle rule in plain integers.
module tb_vga_pixel_source;
    import vga_pkg::*;

    localparam int     SPR_W  = 32;
    localparam int     SPR_H  = 24;
    localparam color_t BG     = 12'h0C4;
    localparam color_t SPR    = 12'h0FF;
    localparam color_t BORDER = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [15:0] frame_cnt;

    vga_pixel_source_if bus ();

    vga_pixel_source #(
        .SPR_W     (SPR_W),
        .SPR_H     (SPR_H),
        .BG_COLOR  (BG),
        .SPR_COLOR (SPR)
    ) dut (
        .clk_25MHz   (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #20 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit m_in_frame;
    bit m_fs;
    int m_cnt;
    int m_sx;
    int m_sy;

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_fs       = 1'b0;
        m_cnt      = 0;
        m_sx       = 0;
        m_sy       = 0;
    endtask

    function automatic color_t m_pixel(int r, int c, bit n);
        if (n) return 12'h000;
`ifdef VGA_PIXEL_BORDER_EN
        if (r == 0 || r == 479 || c == 0 || c == 639) return BORDER;
`endif
        if (c >= m_sx && c < m_sx + SPR_W && r >= m_sy && r < m_sy + SPR_H) return SPR;
        return BG;
    endfunction

    // Apply the frame rules to the request being presented at this edge.
    task automatic model_edge();
        int  r = int'(bus.row);
        int  c = int'(bus.col);
        bit  rd = bus.rdn;
        if (rst) return;
        if (bus.upd_valid && !m_in_frame) begin
            m_sx = int'(bus.upd_x);
            m_sy = int'(bus.upd_y);
        end
        m_fs = 1'b0;
        if (!m_in_frame && !rd && r == 0 && c == 0) begin
            m_in_frame = 1'b1;
            m_fs       = 1'b1;
            m_cnt      = (m_cnt + 1) % 65536;
        end else if (m_in_frame && !rd && r == 479 && c == 639) begin
            m_in_frame = 1'b0;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, "/Din"}, 32'(bus.Din), 32'(m_pixel(int'(bus.row), int'(bus.col), bus.rdn)));
        chk({tag, "/upd_ready"}, 32'(bus.upd_ready), 32'(!m_in_frame));
        chk({tag, "/frame_start"}, 32'(frame_start), 32'(m_fs));
        chk({tag, "/frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
    endtask

    task automatic drive(int r, int c, bit n);
        bus.row = 9'(r);
        bus.col = 10'(c);
        bus.rdn = n;
        #1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(bit v, int x, int y);
        bus.upd_valid = v;
        bus.upd_x     = 10'(x);
        bus.upd_y     = 9'(y);
    endtask

    initial begin
        rst = 1'b1;
        offer(0, 0, 0);
        drive(200, 300, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");

        // Bring up one frame, then reset in the middle of it.
        rst = 1'b0;
        drive(0, 0, 0);
        chk_all("pre_sof");
        tick();
        chk_all("sof_pulse");
        drive(200, 300, 0);
        tick();
        chk_all("mid_frame");
        #5 rst = 1'b1;
        #1 model_reset();
        chk_all("async_reset");
        tick();
        rst = 1'b0;

        // Partial frame after reset is ignored, even its last pixel.
        drive(200, 301, 0);
        tick();
        chk_all("partial");
        drive(479, 639, 0);
        tick();
        chk_all("partial_last");
        drive(0, 0, 0);
        tick();
        chk_all("sof_after_reset");
        tick();
        chk_all("pulse_one_cycle");
        drive(479, 639, 0);
        tick();
        chk_all("to_vblank");

        // Place the sprite at (100,50) and probe its corners.
        offer(1, 100, 50);
        tick();
        offer(0, 0, 0);
        drive(50, 100, 0);  chk_all("spr_tl");
        chk("spr_tl_const", 32'(bus.Din), 32'h0FF);
        drive(50, 131, 0);  chk_all("spr_tr");
        drive(50, 132, 0);  chk_all("spr_right_out");
        chk("spr_right_const", 32'(bus.Din), 32'h0C4);
        drive(74, 100, 0);  chk_all("spr_bottom_out");
        drive(73, 131, 0);  chk_all("spr_br");
        drive(49, 100, 0);  chk_all("spr_top_out");
        drive(50, 100, 1);  chk_all("rdn_high");
        chk("rdn_high_const", 32'(bus.Din), 32'h000);

        // Update offered mid-frame stalls until the frame has ended.
        drive(0, 0, 0);
        tick();
        chk_all("stall_sof");
        offer(1, 200, 300);
        drive(10, 5, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("stall_hold");
        end
        drive(50, 100, 0);  chk_all("stall_old_sprite");
        drive(300, 200, 0); chk_all("stall_new_not_yet");
        drive(479, 639, 0); chk_all("stall_last");
        tick();
        chk_all("stall_vblank");
        drive(300, 200, 0); chk_all("stall_pre_accept");
        tick();
        offer(0, 0, 0);
        chk_all("stall_accepted");
        drive(0, 0, 0);
        tick();
        drive(300, 200, 0); chk_all("stall_new_frame");
        drive(479, 639, 0);
        tick();

        // Sprite hanging off the bottom-right corner is clipped, not wrapped.
        offer(1, 620, 470);
        tick();
        offer(0, 0, 0);
        drive(475, 639, 0); chk_all("clip_edge");
        drive(475, 0, 0);   chk_all("clip_no_wrap");
        drive(0, 630, 0);   chk_all("clip_no_row_wrap");

        // Randomized positions, requests and update offers.
        for (int f = 0; f < 6; f++) begin
            offer(1, int'($urandom_range(700)), int'($urandom_range(520)));
            drive(0, 0, 0);
            tick();
            chk_all("rnd_sof");
            for (int q = 0; q < 25; q++) begin
                offer(bit'($urandom_range(1)), int'($urandom_range(1023)), int'($urandom_range(511)));
                drive(int'($urandom_range(479)), int'($urandom_range(639)), bit'($urandom_range(1)));
                chk_all("rnd_px");
                tick();
            end
            offer(0, 0, 0);
            drive(479, 639, 0);
            tick();
            chk_all("rnd_eof");
        end

        // Counter wrap: preload near the top, then run short frames.
        drive(5, 5, 0);
        force dut.frame_cnt = 16'hFFF0;
        tick();
        release dut.frame_cnt;
        m_cnt = 16'hFFF0;
        chk_all("preload");
        for (int f = 0; f < 20; f++) begin
            drive(0, 0, 0);
            tick();
            chk_all("wrap_sof");
            drive(479, 639, 0);
            tick();
            chk_all("wrap_eof");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
